rfile_wb_arb: RTL and testbench
===============================

RFILE_WB_ARB -- requirements
Module: rfile_wb_arb

Interface
REQ-001 Parameter XLEN, default 64: register width in bits.
REQ-002 Parameter XWDT, default 6: register index width.
REQ-003 Parameter NREQ, default 4: number of writeback requesters.
REQ-004 Parameter NPORT, default 3: number of register-file write ports driven; the block SHALL support NREQ >= NPORT >= 1.
REQ-005 clk  in  1: single clock; all state updates on its rising edge.
REQ-006 rst  in  1: reset, asynchronous, active-high.
REQ-007 stall  in  1: when high, no new grants are issued.
REQ-008 req_valid  in  [NREQ]: per-requester write request valid.
REQ-009 req_ready  out  [NREQ]: per-requester grant; the request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-010 req_reg  in  [NREQ][XWDT]: destination register index.
REQ-011 req_data  in  [NREQ][XLEN]: write data, right-aligned.
REQ-012 req_size  in  [NREQ][2]: write size; 00 byte, 01 half, 10 word, 11 full.
REQ-013 req_pos  in  [NREQ][3]: lane position within the register, in units of the size.
REQ-014 rwrites  out  [NPORT][XWDT]: register index for each write port.
REQ-015 rins  out  [NPORT][XLEN]: data for each write port.
REQ-016 rwsizes  out  [NPORT][2]: size for each write port.
REQ-017 rwposs  out  [NPORT][3]: position for each write port.
REQ-018 we  out  1: common write enable for all ports.
REQ-019 busy  out  1: high while any req_valid is high and was not granted this cycle.

Function
REQ-020 Combinational grant: when stall=0, up to NPORT requesters SHALL be granted per cycle.
REQ-021 Grant order SHALL be round-robin, starting at pointer rr_ptr and scanning upward with modulo-NREQ wrap.
REQ-022 At most one grant per destination register per cycle; a later-scanned requester targeting an already-granted register SHALL be skipped and held off (req_ready=0).
REQ-023 Grants SHALL fill ports 0..k-1 in scan order.
REQ-024 Latency: an accepted request SHALL appear on its port, with we=1, exactly one cycle after acceptance; all port outputs are registered.
REQ-025 Unused ports: in a cycle with k grants (1 <= k < NPORT), ports k..NPORT-1 SHALL carry an exact copy of port 0's fields, making the redundant writes idempotent under the shared we.
REQ-026 Zero grants (no valid requests, stall=1, or reset): we SHALL be 0 on the next cycle and the port fields SHALL hold their previous values.
REQ-027 rr_ptr update: rr_ptr SHALL become (index of last granted requester + 1) mod NREQ, and SHALL be unchanged when no grant is issued.
REQ-028 Position normalisation before registering:
- half: pos[1:0] is used and pos[2] is forced to 0;
- word: pos[0] is used and pos[2:1] are forced to 0;
- full: pos is forced to 0;
- byte: pos is passed unchanged.
REQ-029 Data SHALL be passed unmodified; lane alignment is performed by the register file.
REQ-030 stall asserted while we=1 SHALL NOT cancel the write already registered; it only blocks new grants.
REQ-031 req_ready SHALL depend only on req_valid, req_reg, stall and rr_ptr; it SHALL NOT depend on req_data, req_size or req_pos.

Reset
REQ-032 On rst high, immediately:
- we=0 and rr_ptr=0;
- rwrites, rins, rwsizes and rwposs are all 0;
- req_ready and busy are 0.
REQ-033 Reset asserted with a write registered but not yet performed SHALL discard that write; no we pulse follows reset release.
REQ-034 The first grant after reset release SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-035 Shared package rfile_pkg SHALL hold:
- XLEN and XWDT defaults;
- size encoding constants SZ_B, SZ_H, SZ_W, SZ_D;
- a write-request struct {reg, data, size, pos}.
REQ-036 One sub-module, rfile_rr_pick, SHALL implement the rotating-priority scan with register-conflict masking, returning per-port requester indices and a port-valid mask.

Verification
REQ-037 NREQ=4, NPORT=3; requesters 0..3 valid for regs 5, 6, 7, 8; rr_ptr=0 -> req_ready=0111; next cycle ports = 5, 6, 7 with we=1; rr_ptr=3; the following cycle grants requester 3 only; ports 1 and 2 mirror port 0 (reg 8).
REQ-038 Requesters 0 and 2 both target reg 9; rr_ptr=0 -> only requester 0 is granted and busy=1; the next cycle grants requester 2 and busy=0.
REQ-039 Requester 1: size=01, pos=7, data=0xABCD -> next cycle rwsizes[0]=01, rwposs[0]=3, rins[0]=0xABCD, we=1.
REQ-040 stall=1 with all requesters valid -> req_ready=0000, we=0 on the next cycle, rr_ptr unchanged.
REQ-041 rst pulsed in the cycle after an acceptance -> we=0 immediately; outputs are zero; no write occurs after release.
REQ-042 Two requesters valid continuously for 20 cycles with NPORT=1 -> grants alternate strictly and each requester receives exactly 10.

Source files
------------

// File: rtl/rfile_pkg.sv
// rfile_pkg: shared widths, size encodings, request struct and lane-position normalisation.
package rfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int XWDT_DEF = 6;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  typedef struct packed {
    logic [XWDT_DEF-1:0] rnum;
    logic [XLEN_DEF-1:0] data;
    logic [1:0]          size;
    logic [2:0]          pos;
  } wreq_t;
  // Position bits beyond the number of lanes of the given size are cleared.
  function automatic logic [2:0] norm_pos(input logic [1:0] size, input logic [2:0] pos);
    case (size)
      SZ_B: return pos;
      SZ_H: return {1'b0, pos[1:0]};
      SZ_W: return {2'b0, pos[0]};
      SZ_D: return 3'b0;
    endcase
  endfunction
endpackage

// File: rtl/rfile_rr_pick.sv
// rfile_rr_pick: rotating-priority scan granting up to NPORT requesters with distinct destination registers.
module rfile_rr_pick #(
  parameter int NREQ  = 4,
  parameter int NPORT = 3,
  parameter int XWDT  = 6,
  parameter int IW    = 2
) (
  input  logic [NREQ-1:0]           valid,
  input  logic [NREQ-1:0][XWDT-1:0] regs,
  input  logic [IW-1:0]             ptr,
  input  logic                      en,
  output logic [NPORT-1:0][IW-1:0]  idx,
  output logic [NPORT-1:0]          pvalid,
  output logic [NREQ-1:0]           grant,
  output logic [IW-1:0]             last
);
  logic [IW-1:0] r;
  logic          hit;
  logic          take;
  int            n;
  always_comb begin
    idx    = '0;
    pvalid = '0;
    grant  = '0;
    last   = ptr;
    r      = '0;
    hit    = 1'b0;
    take   = 1'b0;
    n      = 0;
    for (int s = 0; s < NREQ; s++) begin
      r   = IW'((int'(ptr) + s) % NREQ);
      hit = 1'b0;
      for (int p = 0; p < NPORT; p++)
        hit = hit | (pvalid[p] && regs[idx[p]] == regs[r]);
      take = en && valid[r] && n < NPORT && !hit;
      for (int p = 0; p < NPORT; p++)
        if (take && p == n) begin
          idx[p]    = r;
          pvalid[p] = 1'b1;
        end
      if (take) begin
        grant[r] = 1'b1;
        last     = r;
        n        = n + 1;
      end
    end
  end
endmodule

// File: rtl/rfile_wb_arb.sv
// rfile_wb_arb: round-robin writeback arbiter packing granted requests onto registered register-file write ports.
module rfile_wb_arb
  import rfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int XWDT  = XWDT_DEF,
  parameter int NREQ  = 4,
  parameter int NPORT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][XWDT-1:0]  req_reg,
  input  logic [NREQ-1:0][XLEN-1:0]  req_data,
  input  logic [NREQ-1:0][1:0]       req_size,
  input  logic [NREQ-1:0][2:0]       req_pos,
  output logic [NPORT-1:0][XWDT-1:0] rwrites,
  output logic [NPORT-1:0][XLEN-1:0] rins,
  output logic [NPORT-1:0][1:0]      rwsizes,
  output logic [NPORT-1:0][2:0]      rwposs,
  output logic                       we,
  output logic                       busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            last;
  logic [NPORT-1:0][IW-1:0] idx;
  logic [NPORT-1:0][IW-1:0] sel;
  logic [NPORT-1:0]         pvalid;
  logic [NREQ-1:0]          grant;
  rfile_rr_pick #(.NREQ(NREQ), .NPORT(NPORT), .XWDT(XWDT), .IW(IW)) u_pick (
    .valid  (req_valid),
    .regs   (req_reg),
    .ptr    (rr_ptr),
    .en     (!stall && !rst),
    .idx    (idx),
    .pvalid (pvalid),
    .grant  (grant),
    .last   (last)
  );
  assign req_ready = grant;
  assign busy      = !rst && |(req_valid & ~grant);
  // Empty ports replay port 0 so the shared enable writes the same value twice.
  always_comb
    for (int p = 0; p < NPORT; p++)
      sel[p] = pvalid[p] ? idx[p] : idx[0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we      <= 1'b0;
      rr_ptr  <= '0;
      rwrites <= '0;
      rins    <= '0;
      rwsizes <= '0;
      rwposs  <= '0;
    end else begin
      we <= |grant;
      if (|grant) begin
        rr_ptr <= last == IW'(NREQ - 1) ? '0 : last + 1'b1;
        for (int p = 0; p < NPORT; p++) begin
          rwrites[p] <= req_reg[sel[p]];
          rins[p]    <= req_data[sel[p]];
          rwsizes[p] <= req_size[sel[p]];
          rwposs[p]  <= norm_pos(req_size[sel[p]], req_pos[sel[p]]);
        end
      end
    end
endmodule

// File: tb/tb_rfile_wb_arb.sv
// tb_rfile_wb_arb: directed checks of grant order, conflicts, mirroring, normalisation, stall, reset and fairness.
module tb_rfile_wb_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0]       v1 = '0;
  logic [3:0][5:0]  req_reg = '0;
  logic [3:0][63:0] req_data = '0;
  logic [3:0][1:0]  req_size = '0;
  logic [3:0][2:0]  req_pos = '0;
  logic [3:0]       req_ready;
  logic [2:0][5:0]  rwrites;
  logic [2:0][63:0] rins;
  logic [2:0][1:0]  rwsizes;
  logic [2:0][2:0]  rwposs;
  logic             we, busy;
  logic [3:0]       r1_ready;
  logic [0:0][5:0]  w1_reg;
  logic [0:0][63:0] w1_data;
  logic [0:0][1:0]  w1_size;
  logic [0:0][2:0]  w1_pos;
  logic             we1, busy1;
  int checks = 0;
  int errors = 0;
  int cnt0 = 0;
  int cnt1 = 0;

  rfile_wb_arb #(.XLEN(64), .XWDT(6), .NREQ(4), .NPORT(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .req_size(req_size), .req_pos(req_pos),
    .rwrites(rwrites), .rins(rins), .rwsizes(rwsizes), .rwposs(rwposs), .we(we), .busy(busy)
  );

  rfile_wb_arb #(.XLEN(64), .XWDT(6), .NREQ(4), .NPORT(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(v1), .req_ready(r1_ready),
    .req_reg(req_reg), .req_data(req_data), .req_size(req_size), .req_pos(req_pos),
    .rwrites(w1_reg), .rins(w1_data), .rwsizes(w1_size), .rwposs(w1_pos), .we(we1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_we", we, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rwrites", rwrites, '0);
    chk("rst_ptr", dut.rr_ptr, 2'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_reg[i]  = 6'(5 + i);
      req_data[i] = 64'h100 + 64'(i);
      req_size[i] = 2'b11;
      req_pos[i]  = 3'd7;
    end
    req_valid = 4'b1111;
    #1;
    chk("t1_ready", req_ready, 4'b0111);
    chk("t1_busy", busy, 1'b1);
    step();
    chk("t1_we", we, 1'b1);
    chk("t1_rwrites", rwrites, {6'd7, 6'd6, 6'd5});
    chk("t1_rins", rins, {64'h102, 64'h101, 64'h100});
    chk("t1_rwposs", rwposs, 9'd0);
    chk("t1_ptr", dut.rr_ptr, 2'd3);
    req_valid = 4'b1000;
    #1;
    chk("t1b_ready", req_ready, 4'b1000);
    chk("t1b_busy", busy, 1'b0);
    step();
    chk("t1b_we", we, 1'b1);
    chk("t1b_mirror_reg", rwrites, {3{6'd8}});
    chk("t1b_mirror_data", rins, {3{64'h103}});
    chk("t1b_ptr", dut.rr_ptr, 2'd0);
    req_reg[0] = 6'd9;
    req_reg[2] = 6'd9;
    req_valid = 4'b0101;
    #1;
    chk("t2_ready", req_ready, 4'b0001);
    chk("t2_busy", busy, 1'b1);
    step();
    chk("t2_we", we, 1'b1);
    chk("t2_reg", rwrites[0], 6'd9);
    chk("t2_ptr", dut.rr_ptr, 2'd1);
    req_valid = 4'b0100;
    #1;
    chk("t2b_ready", req_ready, 4'b0100);
    chk("t2b_busy", busy, 1'b0);
    step();
    chk("t2b_we", we, 1'b1);
    chk("t2b_ptr", dut.rr_ptr, 2'd3);
    req_valid = 4'b0000;
    step();
    chk("idle_we", we, 1'b0);
    chk("idle_hold", rwrites, {3{6'd9}});
    req_reg[1]  = 6'd3;
    req_size[1] = 2'b01;
    req_pos[1]  = 3'd7;
    req_data[1] = 64'hABCD;
    req_valid = 4'b0010;
    #1;
    chk("t3_ready", req_ready, 4'b0010);
    step();
    chk("t3_we", we, 1'b1);
    chk("t3_size", rwsizes, {3{2'b01}});
    chk("t3_pos", rwposs, {3{3'd3}});
    chk("t3_data", rins[0], 64'hABCD);
    chk("t3_ptr", dut.rr_ptr, 2'd2);
    stall = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t4_ready", req_ready, 4'b0000);
    chk("t4_busy", busy, 1'b1);
    step();
    chk("t4_we", we, 1'b0);
    chk("t4_ptr", dut.rr_ptr, 2'd2);
    chk("t4_hold", rwrites, {3{6'd3}});
    stall = 1'b0;
    req_reg[0] = 6'd10;
    req_valid = 4'b0001;
    #1;
    chk("t5_ready", req_ready, 4'b0001);
    step();
    chk("t5_we", we, 1'b1);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t5_rst_we", we, 1'b0);
    chk("t5_rst_reg", rwrites, '0);
    chk("t5_rst_data", rins, '0);
    chk("t5_rst_ready", req_ready, 4'b0000);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ptr", dut.rr_ptr, 2'd0);
    req_valid = 4'b0000;
    step();
    rst = 1'b0;
    step();
    chk("t5_post1_we", we, 1'b0);
    step();
    chk("t5_post2_we", we, 1'b0);
    req_reg[0]  = 6'd1;
    req_size[0] = 2'b00;
    req_pos[0]  = 3'd5;
    req_reg[2]  = 6'd2;
    req_size[2] = 2'b10;
    req_pos[2]  = 3'd7;
    req_valid = 4'b0101;
    #1;
    chk("t6_ready", req_ready, 4'b0101);
    step();
    chk("t6_reg", rwrites, {6'd1, 6'd2, 6'd1});
    chk("t6_size", rwsizes, {2'b00, 2'b10, 2'b00});
    chk("t6_pos", rwposs, {3'd5, 3'd1, 3'd5});
    req_valid = 4'b0000;
    req_reg[1] = 6'd2;
    v1 = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("t7_ready", r1_ready, (c % 2) ? 4'b0010 : 4'b0001);
      if (r1_ready == 4'b0001) cnt0++;
      if (r1_ready == 4'b0010) cnt1++;
      step();
      chk("t7_reg", w1_reg[0], (c % 2) ? 6'd2 : 6'd1);
    end
    v1 = 4'b0000;
    chk("t7_cnt0", cnt0, 10);
    chk("t7_cnt1", cnt1, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
